uart_tx_cfg: RTL
================

Name: uart_tx_cfg

Overview:
Parametrised UART transmitter, the successor to the fixed 8N1 transmitter.
- Runtime-configurable frame: 5..DATA_WIDTH data bits, none/even/odd/mark parity, 1 or 2 stop bits.
- Adds break generation, a FIFO fill level, an overflow flag and a frame-done pulse.
- Sits behind the peripheral register block and drives the TX pad through a buffered FIFO.

Parameters:
- DATA_WIDTH, 8, maximum data bits per frame; legal 5..9; sets the FIFO word width.
- FIFO_DEPTH, 16, FIFO entries; power of 2, at least 2.
- LVL_W, $clog2(FIFO_DEPTH)+1, width of the level output.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- baud_div_i  in  16  clocks per bit period; 0 is treated as 1.
- data_bits_i  in  4  data bits per frame; values <5 or >DATA_WIDTH clamp to DATA_WIDTH.
- parity_i  in  2  00 none, 01 even, 10 odd, 11 mark (constant 1).
- stop2_i  in  1  0 = one stop bit, 1 = two stop bits.
- tx_en_i  in  1  enables starting new frames.
- brk_i  in  1  break request.
- tx_we_i  in  1  FIFO write strobe.
- din_i  in  DATA_WIDTH  write data, LSB sent first.
- tx_o  out  1  serial line, registered.
- busy_o  out  1  high when state is not IDLE.
- done_o  out  1  one-cycle pulse at the end of the last stop bit.
- ovf_o  out  1  one-cycle pulse when a write is dropped.
- empty_o  out  1  FIFO empty.
- full_o  out  1  FIFO full.
- level_o  out  LVL_W  FIFO occupancy, 0..FIFO_DEPTH.

Behaviour:
- Reset (async, rst_ni=0): tx_o=1, busy_o=0, done_o=0, ovf_o=0, empty_o=1, full_o=0, level_o=0.
  - State returns to IDLE and all counters clear.
  - Reset mid-frame aborts the frame, returns the line to 1 immediately and flushes the FIFO.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- Bit period P = max(baud_div_i, 1) clocks.
  - The baud counter runs 0..P-1 in every non-IDLE state except BREAK.
  - It restarts at 0 on each state entry.
- IDLE:
  - If brk_i=1, go to BREAK. brk_i has priority over FIFO data.
  - Else if tx_en_i=1 and FIFO not empty: pop, latch the data word and configuration (data_bits, parity, stop2), go to START.
  - tx_o goes 0 on the clock edge after the pop.
- START: drive 0 for P clocks, then go to DATA.
- DATA:
  - Drive data_q[bit_cnt] for P clocks per bit, bit_cnt from 0 to n-1.
  - After bit n-1, go to PARITY if parity is not none, else STOP.
- PARITY: drive one bit for P clocks, then go to STOP.
  - Even: XOR of the n sent bits.
  - Odd: inverted XOR.
  - Mark: 1.
  - Bits above n are excluded from the parity calculation.
- STOP:
  - Drive 1 for P clocks, or 2P clocks if stop2 was latched.
  - At the final clock, pulse done_o.
  - If brk_i=1, go to BREAK.
  - Else if tx_en_i=1 and FIFO not empty, pop and go to START (back-to-back frames, no idle gap).
  - Else go to IDLE.
- BREAK: drive 0 while brk_i=1. When brk_i falls, go to STOP with one stop bit (mark for P clocks); no done_o pulse for this STOP.
- Configuration inputs change only at frame boundaries. Mid-frame changes have no effect on the current frame.
- tx_en_i falling mid-frame: the current frame completes and no new pop occurs.
- FIFO writes:
  - tx_we_i with full_o=1 drops the word and pulses ovf_o.
  - This holds even if a pop occurs in the same cycle.
  - Write and pop in the same cycle when not full or empty: level_o is unchanged.
- level_o is updated the cycle after a write or pop. It wraps never and saturates structurally at FIFO_DEPTH.
- Frame length in clocks = P × (1 + n + parity_en + 1 + stop2).

Decomposition:
- Package uart_pkg holds:
  - parity_e enum (PAR_NONE, PAR_EVEN, PAR_ODD, PAR_MARK).
  - tx_state_e enum.
  - Constants MIN_DATA_BITS=5 and MAX_DATA_BITS=9.
- Sub-module: reuse the existing wbit_fifo (DATA_WIDTH, FIFO_DEPTH).
  - Its reset input is driven by !rst_ni.
  - level_o is a local up/down counter in uart_tx_cfg.

Test Plan:
- baud_div=4, 8N1, write 0xA5, tx_en=1:
  - tx_o gives 0,1,0,1,0,0,1,0,1,1, each bit held 4 clocks.
  - Total 40 clocks; done_o pulses once at clock 40; busy_o drops the next cycle.
- baud_div=2, 7 data bits, even parity, write 0x55:
  - Data bits 1,0,1,0,1,0,1, then parity 0, then stop 1.
  - Total 20 clocks.
- baud_div=3, 8 data bits, odd parity, stop2=1, write 0x00 and 0xFF back-to-back:
  - Frame 1 parity 1, frame 2 parity 1.
  - Each frame 36 clocks with no idle gap between frames.
  - done_o pulses twice.
- tx_en=0, 17 writes, DEPTH=16:
  - full_o=1 and level_o=16 after write 16.
  - ovf_o pulses on write 17; level_o stays 16.
- brk_i=1 for 50 clocks during a frame, baud_div=4:
  - The current frame completes first.
  - tx_o is then 0 for 50 clocks, 1 for 4 clocks, then the next queued frame starts.
- rst_ni low for 1 cycle mid-DATA:
  - tx_o=1 immediately; busy_o=0, level_o=0, empty_o=1.
  - No done_o pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and limits for the configurable UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_MARK = 2'b11
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } tx_state_e;

  localparam int MIN_DATA_BITS = 5;
  localparam int MAX_DATA_BITS = 9;

endpackage

// File: rtl/wbit_fifo.sv
// Show-ahead FIFO: rdata always presents the oldest entry, writes to a full FIFO are ignored.
module wbit_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  empty,
  output logic                  full
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;

  assign wr_ok = we && !full;
  assign rd_ok = re && !empty;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: 5..DATA_WIDTH data bits, optional parity, 1/2 stop bits,
// break generation, buffered through a FIFO with occupancy and overflow reporting.
module uart_tx_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [15:0]           baud_div_i,
  input  logic [3:0]            data_bits_i,
  input  logic [1:0]            parity_i,
  input  logic                  stop2_i,
  input  logic                  tx_en_i,
  input  logic                  brk_i,
  input  logic                  tx_we_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  ovf_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [LVL_W-1:0]      level_o
);

  import uart_pkg::*;

  tx_state_e             state, state_nx;
  logic [15:0]           baud_cnt, baud_nx;
  logic [15:0]           p_q, p_nx, p_in;
  logic [3:0]            bit_cnt, bit_nx;
  logic [3:0]            n_q;
  logic                  stop_cnt, stop_nx;
  logic                  brk_stop, brk_stop_nx;
  logic                  baud_last;
  logic                  pop;
  logic                  tx, tx_nx;
  logic                  done, done_nx;
  logic                  ovf;
  logic [LVL_W-1:0]      level;
  logic [DATA_WIDTH-1:0] data_q, data_sh, fifo_rdata;
  parity_e               par_q;
  logic                  stop2_q;
  logic                  fifo_empty, fifo_full, fifo_rst, wr_ok;

  function automatic logic [3:0] clamp_bits(input logic [3:0] d);
    if (int'(d) < MIN_DATA_BITS || int'(d) > DATA_WIDTH) return 4'(DATA_WIDTH);
    return d;
  endfunction

  // Only the n transmitted bits take part in the parity.
  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d,
                                      input logic [3:0] n, input parity_e par);
    logic [DATA_WIDTH-1:0] m;
    for (int i = 0; i < DATA_WIDTH; i++) m[i] = (i < int'(n));
    case (par)
      PAR_EVEN: return ^(d & m);
      PAR_ODD:  return ~^(d & m);
      default:  return 1'b1;
    endcase
  endfunction

  assign fifo_rst = ~rst_ni;
  assign wr_ok    = tx_we_i && !fifo_full;

  wbit_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (fifo_rst),
    .we    (tx_we_i),
    .wdata (din_i),
    .re    (pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign p_in      = (baud_div_i == 16'd0) ? 16'd1 : baud_div_i;
  assign baud_last = (baud_cnt == p_q - 16'd1);

  always_comb begin
    state_nx    = state;
    baud_nx     = baud_cnt + 16'd1;
    bit_nx      = bit_cnt;
    stop_nx     = stop_cnt;
    brk_stop_nx = brk_stop;
    p_nx        = p_q;
    pop         = 1'b0;
    case (state)
      ST_IDLE: begin
        baud_nx = 16'd0;
        if (brk_i) begin
          state_nx = ST_BREAK;
          p_nx     = p_in;
        end else if (tx_en_i && !fifo_empty) begin
          pop      = 1'b1;
          p_nx     = p_in;
          state_nx = ST_START;
        end
      end
      ST_START: begin
        if (baud_last) begin
          baud_nx  = 16'd0;
          bit_nx   = 4'd0;
          state_nx = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_nx = 16'd0;
          if (bit_cnt == n_q - 4'd1) begin
            state_nx    = (par_q != PAR_NONE) ? ST_PARITY : ST_STOP;
            stop_nx     = 1'b0;
            brk_stop_nx = 1'b0;
          end else begin
            bit_nx = bit_cnt + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (baud_last) begin
          baud_nx     = 16'd0;
          state_nx    = ST_STOP;
          stop_nx     = 1'b0;
          brk_stop_nx = 1'b0;
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          baud_nx = 16'd0;
          if (!stop_cnt && stop2_q && !brk_stop) begin
            stop_nx = 1'b1;
          end else if (brk_i) begin
            state_nx = ST_BREAK;
            p_nx     = p_in;
          end else if (tx_en_i && !fifo_empty) begin
            pop      = 1'b1;
            p_nx     = p_in;
            state_nx = ST_START;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      ST_BREAK: begin
        baud_nx = 16'd0;
        if (!brk_i) begin
          state_nx    = ST_STOP;
          stop_nx     = 1'b0;
          brk_stop_nx = 1'b1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        baud_nx  = 16'd0;
      end
    endcase
  end

  assign data_sh = data_q >> bit_nx;

  always_comb begin
    case (state_nx)
      ST_START, ST_BREAK: tx_nx = 1'b0;
      ST_DATA:            tx_nx = data_sh[0];
      ST_PARITY:          tx_nx = parity_bit(data_q, n_q, par_q);
      default:            tx_nx = 1'b1;
    endcase
  end

  // done is registered, so it is raised on the edge that enters the last stop clock.
  assign done_nx = (state_nx == ST_STOP) && !brk_stop_nx && (stop_nx == stop2_q) &&
                   (baud_nx == p_nx - 16'd1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= ST_IDLE;
      baud_cnt <= 16'd0;
      bit_cnt  <= 4'd0;
      stop_cnt <= 1'b0;
      brk_stop <= 1'b0;
      p_q      <= 16'd1;
      tx       <= 1'b1;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_nx;
      bit_cnt  <= bit_nx;
      stop_cnt <= stop_nx;
      brk_stop <= brk_stop_nx;
      p_q      <= p_nx;
      tx       <= tx_nx;
      done     <= done_nx;
    end
  end

  // Frame word and format are captured together at the pop and held for the whole frame.
  always_ff @(posedge clk_i) begin
    if (pop) begin
      data_q  <= fifo_rdata;
      n_q     <= clamp_bits(data_bits_i);
      par_q   <= parity_e'(parity_i);
      stop2_q <= stop2_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level <= '0;
      ovf   <= 1'b0;
    end else begin
      ovf <= tx_we_i && fifo_full;
      if (wr_ok && !pop)      level <= level + LVL_W'(1);
      else if (pop && !wr_ok) level <= level - LVL_W'(1);
    end
  end

  assign tx_o    = tx;
  assign busy_o  = (state != ST_IDLE);
  assign done_o  = done;
  assign ovf_o   = ovf;
  assign empty_o = fifo_empty;
  assign full_o  = fifo_full;
  assign level_o = level;

endmodule
